// File: rtl/alu_exec_ctrl_pkg.sv
// Shared constants for the ALU execute-stage sequencer: widths, ALU op codes
// and FSM state encoding.
package alu_exec_ctrl_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_NREGS  = 4;
    localparam int REG_AW     = 2;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [3:0] ALU_DIV  = 4'b0011;
    localparam logic [3:0] ALU_SHL  = 4'b0100;
    localparam logic [3:0] ALU_SHR  = 4'b0101;
    localparam logic [3:0] ALU_ROL  = 4'b0110;
    localparam logic [3:0] ALU_ROR  = 4'b0111;
    localparam logic [3:0] ALU_AND  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1011;
    localparam logic [3:0] ALU_NAND = 4'b1100;
    localparam logic [3:0] ALU_XNOR = 4'b1101;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/alu_exec_ctrl_regfile.sv
// Small register file for the execute stage: one write port (writeback beats
// external load on the same address), two captured operand reads, one debug read.
module alu_regfile
    import alu_exec_ctrl_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int NREGS  = ALU_NREGS,
    parameter int AW     = REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_en_i,
    input  logic [AW-1:0]     wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              ld_en_i,
    input  logic [AW-1:0]     ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic              cap_en_i,
    input  logic [AW-1:0]     rs_addr_i,
    input  logic [AW-1:0]     rt_addr_i,
    output logic [DATA_W-1:0] op_a_o,
    output logic [DATA_W-1:0] op_b_o,
    input  logic [AW-1:0]     dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wb_en_i && (wb_addr_i == AW'(i))) begin
                    regs_q[i] <= wb_data_i;
                end else if (ld_en_i && (ld_addr_i == AW'(i))) begin
                    regs_q[i] <= ld_data_i;
                end
            end
        end
    end

    // Operands sample the pre-edge contents, so a same-edge load is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q <= '0;
            op_b_q <= '0;
        end else if (cap_en_i) begin
            op_a_q <= regs_q[rs_addr_i];
            op_b_q <= regs_q[rt_addr_i];
        end
    end

    assign op_a_o     = op_a_q;
    assign op_b_o     = op_b_q;
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer around the external 8-bit ALU (only DATA_W=8 is valid).
// Optional divide-by-zero trap enabled by defining ALU_EXEC_DIVZ_EN.
//
//   state | meaning
//   IDLE  | ready; accepts an instruction and captures its operands
//   EXEC  | ALU inputs driven from registers; result written back at next edge
module alu_exec_ctrl
    import alu_exec_ctrl_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int NREGS  = ALU_NREGS,
    parameter int AW     = REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [AW-1:0]     in_rd,
    input  logic [AW-1:0]     in_rs,
    input  logic [AW-1:0]     in_rt,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_cout,
    output logic              done,
    output logic              carry_flag,
    output logic              zero_flag,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state_q, state_d;
    logic [3:0]        sel_q;
    logic [AW-1:0]     dest_q;
    logic              done_q;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic              accept;
    logic              wb_en;
    logic              div_zero;
    logic [DATA_W-1:0] op_a, op_b;
    logic [DATA_W-1:0] wb_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = EXEC;
            EXEC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        accept   = 1'b0;
        wb_en    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = rst_n;
                accept   = in_valid && rst_n;
            end
            EXEC:    wb_en = 1'b1;
            default: ;
        endcase
    end

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (AW)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_en_i    (wb_en),
        .wb_addr_i  (dest_q),
        .wb_data_i  (wb_data),
        .ld_en_i    (ld_en),
        .ld_addr_i  (ld_addr),
        .ld_data_i  (ld_data),
        .cap_en_i   (accept),
        .rs_addr_i  (in_rs),
        .rt_addr_i  (in_rt),
        .op_a_o     (op_a),
        .op_b_o     (op_b),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

`ifdef ALU_EXEC_DIVZ_EN
    assign div_zero = (sel_q == ALU_DIV) && (op_b == '0);
`else
    assign div_zero = 1'b0;
`endif

    // Divide-by-zero saturates the result and reports through the carry flag.
    always_comb begin
        wb_data = alu_out;
        zero_d  = (alu_out == '0);
        carry_d = (sel_q == ALU_ADD) ? alu_cout : carry_q;
        if (div_zero) begin
            wb_data = '1;
            zero_d  = 1'b0;
            carry_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            dest_q  <= '0;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            done_q <= wb_en;
            if (accept) begin
                sel_q  <= in_op;
                dest_q <= in_rd;
            end
            if (wb_en) begin
                carry_q <= carry_d;
                zero_q  <= zero_d;
            end
        end
    end

    assign alu_a      = op_a;
    assign alu_b      = op_b;
    assign alu_sel    = sel_q;
    assign done       = done_q;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;

endmodule
